// File: rtl/z80_bus_target.sv
// Z80 bus target: 64 KiB byte array behind the CPU strobes, with programmable wait states,
// an interrupt-acknowledge vector and a backdoor port. Optional trace ports: Z80_TARGET_TRACE_EN.
module z80_bus_target #(
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] IO_PAGE     = 8'h10,
  parameter logic [7:0] INTA_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  input  logic        bd_we,
  input  logic [15:0] bd_addr,
  input  logic [7:0]  bd_wdata,
  output logic [7:0]  bd_rdata
`ifdef Z80_TARGET_TRACE_EN
  ,
  output logic [15:0] last_wr_addr,
  output logic [7:0]  last_wr_data,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [7:0]  mem [0:65535];

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        inta_q, inta_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wait_n_q, wait_n_d;
  logic [7:0]  di_q, di_d;

  logic intack, start, bus_idle, cpu_commit;

  // mreq wins over iorq, so an M1 opcode fetch never looks like an intack
  assign intack     = !iorq_n && !m1_n && mreq_n;
  assign start      = rfsh_n && ((((!mreq_n || !iorq_n) && (!rd_n || !wr_n))) || intack);
  assign bus_idle   = (rd_n && wr_n) || (mreq_n && iorq_n);
  assign cpu_commit = (state_q == S_ACTIVE) && wr_q;

`ifdef Z80_TARGET_TRACE_EN
  logic [15:0] last_wr_addr_q, last_wr_addr_d;
  logic [7:0]  last_wr_data_q, last_wr_data_d;
  logic [15:0] wr_count_q, wr_count_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    inta_d   = inta_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    di_d     = di_q;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d = !mreq_n ? A : {IO_PAGE, A[7:0]};
        inta_d = intack;
        wr_d   = !wr_n && !intack;
        if (intack || WAIT_CYCLES == 0) begin
          state_d = S_ACTIVE;
        end else begin
          state_d  = S_WAIT;
          wait_n_d = 1'b0;
          cnt_d    = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_ACTIVE;
          wait_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACTIVE: begin
        if (inta_q)     di_d = INTA_VECTOR;
        else if (!wr_q) di_d = mem[addr_q];
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!inta_q && !wr_q) di_d = mem[addr_q];
        if (bus_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef Z80_TARGET_TRACE_EN
  always_comb begin
    last_wr_addr_d = last_wr_addr_q;
    last_wr_data_d = last_wr_data_q;
    wr_count_d     = wr_count_q;
    if (cpu_commit) begin
      last_wr_addr_d = addr_q;
      last_wr_data_d = dout;
      wr_count_d     = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_wr_addr_q <= 16'h0000;
      last_wr_data_q <= 8'h00;
      wr_count_q     <= 16'h0000;
    end else begin
      last_wr_addr_q <= last_wr_addr_d;
      last_wr_data_q <= last_wr_data_d;
      wr_count_q     <= wr_count_d;
    end
  end

  assign last_wr_addr = last_wr_addr_q;
  assign last_wr_data = last_wr_data_q;
  assign wr_count     = wr_count_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 16'h0000;
      wr_q     <= 1'b0;
      inta_q   <= 1'b0;
      cnt_q    <= 4'd0;
      wait_n_q <= 1'b1;
      di_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      inta_q   <= inta_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
      di_q     <= di_d;
    end
  end

  // Array is never reset; the CPU commit is ordered last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (bd_we)      mem[bd_addr] <= bd_wdata;
    if (cpu_commit) mem[addr_q]  <= dout;
  end

  assign bd_rdata = mem[bd_addr];
  assign di       = di_q;
  assign wait_n   = wait_n_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed bench: two targets (0 and 3 wait states) share one emulated Z80 bus.
module tb_z80_bus_target;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_wdata;
  logic [7:0]  di0, di3, bdr0, bdr3;
  logic        wn0, wn3;
`ifdef Z80_TARGET_TRACE_EN
  logic [15:0] la0, la3, wc0, wc3;
  logic [7:0]  ld0, ld3;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  z80_bus_target #(.WAIT_CYCLES(0), .IO_PAGE(8'h10), .INTA_VECTOR(8'hCF)) u0 (
    .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .di(di0),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
    .wait_n(wn0), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bdr0)
`ifdef Z80_TARGET_TRACE_EN
    , .last_wr_addr(la0), .last_wr_data(ld0), .wr_count(wc0)
`endif
  );

  z80_bus_target #(.WAIT_CYCLES(3), .IO_PAGE(8'h10), .INTA_VECTOR(8'hCF)) u3 (
    .clk(clk), .reset_n(reset_n), .A(A), .dout(dout), .di(di3),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
    .wait_n(wn3), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bdr3)
`ifdef Z80_TARGET_TRACE_EN
    , .last_wr_addr(la3), .last_wr_data(ld3), .wr_count(wc3)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_chk(input string tag, input logic [15:0] a, input logic [7:0] e0, input logic [7:0] e3);
    bd_addr = a;
    #1;
    chk({tag, "/u0"}, {8'h00, bdr0}, {8'h00, e0});
    chk({tag, "/u3"}, {8'h00, bdr3}, {8'h00, e3});
  endtask

  task automatic idle_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One bus cycle held for 8 clocks, long enough for both targets to reach HOLD.
  task automatic bus(input bit io, input bit wr, input bit inta, input bit rfsh,
                     input logic [15:0] a, input logic [7:0] d, input bit collide,
                     output logic [7:0] r0, output logic [7:0] r3, output logic [7:0] r0_early,
                     output int wl0, output int wl3);
    @(negedge clk);
    A = a; dout = d;
    mreq_n = (io || inta);
    iorq_n = !(io || inta);
    m1_n   = !inta;
    rd_n   = wr || inta;
    wr_n   = !wr;
    rfsh_n = !rfsh;
    if (collide) begin
      bd_we = 1'b1; bd_addr = a; bd_wdata = ~d;
    end
    wl0 = 0; wl3 = 0; r0_early = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!wn0) wl0++;
      if (!wn3) wl3++;
      if (i == 2) begin
        r0_early = di0;
        bd_we = 1'b0;
      end
    end
    r0 = di0; r3 = di3;
    idle_bus();
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] r0, r3, re, v;
  int wl0, wl3;

  initial begin
    reset_n = 1'b0;
    A = 16'h0000; dout = 8'h00;
    idle_bus();
    bd_we = 1'b0; bd_addr = 16'h0000; bd_wdata = 8'h00;
    #12;
    chk("rst_di0", {8'h00, di0}, 16'h0000);
    chk("rst_di3", {8'h00, di3}, 16'h0000);
    chk("rst_wn0", {15'h0, wn0}, 16'h0001);
    chk("rst_wn3", {15'h0, wn3}, 16'h0001);
    @(negedge clk);
    reset_n = 1'b1;

    bd_write(16'h1ec1, 8'hed);
    bd_write(16'h1ec2, 8'hb8);
    bd_write(16'h6aef, 8'hd6);
    bd_write(16'h6af0, 8'h70);
    bd_write(16'h0055, 8'h3c);
    bd_chk("preload", 16'h6af0, 8'h70, 8'h70);

    // LDDR, BC=2, DE=b5d7, HL=6af0
    bus(0, 0, 0, 0, 16'h6af0, 8'h00, 0, r0, r3, re, wl0, wl3);
    chk("lddr_rd1_u0", {8'h00, r0}, 16'h0070);
    chk("lddr_rd1_u3", {8'h00, r3}, 16'h0070);
    chk("rd_latency_u0", {8'h00, re}, 16'h0070);
    chk("rd1_wait_u0", 16'(wl0), 16'd0);
    chk("rd1_wait_u3", 16'(wl3), 16'd3);
    v = r0;
    bus(0, 1, 0, 0, 16'hb5d7, v, 0, r0, r3, re, wl0, wl3);
    chk("wr1_wait_u0", 16'(wl0), 16'd0);
    chk("wr1_wait_u3", 16'(wl3), 16'd3);
    bus(0, 0, 0, 0, 16'h6aef, 8'h00, 0, r0, r3, re, wl0, wl3);
    chk("lddr_rd2_u0", {8'h00, r0}, 16'h00d6);
    chk("lddr_rd2_u3", {8'h00, r3}, 16'h00d6);
    v = r0;
    bus(0, 1, 0, 0, 16'hb5d6, v, 0, r0, r3, re, wl0, wl3);
    bd_chk("lddr_b5d7", 16'hb5d7, 8'h70, 8'h70);
    bd_chk("lddr_b5d6", 16'hb5d6, 8'hd6, 8'hd6);
`ifdef Z80_TARGET_TRACE_EN
    chk("tr_wc_u0", wc0, 16'd2);
    chk("tr_wc_u3", wc3, 16'd2);
    chk("tr_la_u0", la0, 16'hb5d6);
    chk("tr_ld_u3", {8'h00, ld3}, 16'h00d6);
`endif

    // OUT (0x42),A with A=5a then IN A,(0x42)
    bus(1, 1, 0, 0, 16'h5a42, 8'h5a, 0, r0, r3, re, wl0, wl3);
    bd_chk("out_1042", 16'h1042, 8'h5a, 8'h5a);
    chk("io_wait_u3", 16'(wl3), 16'd3);
    bus(1, 0, 0, 0, 16'h5a42, 8'h00, 0, r0, r3, re, wl0, wl3);
    chk("in_u0", {8'h00, r0}, 16'h005a);
    chk("in_u3", {8'h00, r3}, 16'h005a);

    // Interrupt acknowledge
    bus(0, 0, 1, 0, 16'h0042, 8'h00, 0, r0, r3, re, wl0, wl3);
    chk("inta_u0", {8'h00, r0}, 16'h00cf);
    chk("inta_u3", {8'h00, r3}, 16'h00cf);
    chk("inta_wait_u3", 16'(wl3), 16'd0);
    bd_chk("inta_noacc", 16'h1042, 8'h5a, 8'h5a);

    // Refresh with a forced write strobe must be ignored
    bus(0, 1, 0, 1, 16'h0055, 8'hff, 0, r0, r3, re, wl0, wl3);
    chk("rfsh_di_u0", {8'h00, r0}, 16'h00cf);
    chk("rfsh_di_u3", {8'h00, r3}, 16'h00cf);
    chk("rfsh_wait_u3", 16'(wl3), 16'd0);
    bd_chk("rfsh_0055", 16'h0055, 8'h3c, 8'h3c);
`ifdef Z80_TARGET_TRACE_EN
    chk("rfsh_wc_u0", wc0, 16'd3);
`endif

    // Backdoor write collides with the CPU commit on the same address
    bus(0, 1, 0, 0, 16'h4000, 8'ha5, 1, r0, r3, re, wl0, wl3);
    bd_chk("collide_4000", 16'h4000, 8'ha5, 8'ha5);

    // Reset during the wait phase of a write to 2000
    bd_write(16'h2000, 8'h11);
    @(negedge clk);
    A = 16'h2000; dout = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_wn3", {15'h0, wn3}, 16'h0000);
    reset_n = 1'b0;
    #1;
    chk("midrst_wn3", {15'h0, wn3}, 16'h0001);
    chk("midrst_di3", {8'h00, di3}, 16'h0000);
    idle_bus();
    bd_write(16'h3000, 8'h77);
    @(negedge clk);
    reset_n = 1'b1;
    bd_chk("rst_bd_3000", 16'h3000, 8'h77, 8'h77);
    bd_chk("rst_2000", 16'h2000, 8'h99, 8'h11);
`ifdef Z80_TARGET_TRACE_EN
    chk("rst_wc_u0", wc0, 16'd0);
    chk("rst_wc_u3", wc3, 16'd0);
`endif
    bus(0, 0, 0, 0, 16'h2000, 8'h00, 0, r0, r3, re, wl0, wl3);
    chk("post_rst_rd_u0", {8'h00, r0}, 16'h0099);
    chk("post_rst_rd_u3", {8'h00, r3}, 16'h0011);
    chk("post_rst_wait_u3", 16'(wl3), 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end
endmodule
